// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: FSM state encoding,
// default reset PC, sequential fetch increment and target alignment mask.
package branch_redirect_ctrl_pkg;

    // RUN: normal sequential fetch. REDIR: taken-branch target captured,
    // waiting for instruction memory to accept it.
    typedef enum logic {
        S_RUN   = 1'b0,
        S_REDIR = 1'b1
    } redir_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_INC   = 4;

    // Low address bits forced to zero on a branch target (word alignment).
    localparam int unsigned ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter used for the taken-branch statistic.
// Counts one per cycle while inc_i is high and sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: owns the fetch PC, redirects it on a taken
// ID-stage branch, squashes the wrong-path instruction in IF/ID and holds a
// pending redirect while instruction memory is not ready.
// Optional feature macro: BRANCH_PERF_CNT_EN (saturating taken-branch counter
// on taken_cnt; when undefined taken_cnt is tied to zero).
//
// Handshake: a fetch at pc completes in any cycle where imem_ready is high;
// the PC only advances (sequentially or to a target) on such a cycle, and a
// redirect accepted while imem_ready is low is parked in redirect_q until
// imem_ready rises.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned          WIDTH_I  = 32,
    parameter logic [WIDTH_I-1:0]   RESET_PC = WIDTH_I'(DEFAULT_RESET_PC),
    parameter int unsigned          PC_INC   = DEFAULT_PC_INC,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_ctrl,
    input  logic [WIDTH_I-1:0] branch_target,
    input  logic               stall,
    input  logic               imem_ready,
    output logic [WIDTH_I-1:0] pc,
    output logic [WIDTH_I-1:0] pc_next_seq,
    output logic               if_id_flush,
    output logic               redirect_pend,
    output logic [CNT_W-1:0]   taken_cnt
);

    localparam logic [WIDTH_I-1:0] TGT_MASK = ~WIDTH_I'(ALIGN_MASK);

    redir_state_e       state_q, state_d;
    logic [WIDTH_I-1:0] pc_q, pc_d;
    logic [WIDTH_I-1:0] redirect_q, redirect_d;
    logic [WIDTH_I-1:0] tgt;
    logic               acc;

    // Targets are silently word-aligned; misalignment is not a fault here.
    assign tgt         = branch_target & TGT_MASK;
    assign pc_next_seq = pc_q + WIDTH_I'(PC_INC);

    // A branch is accepted only in RUN and only when the comparator operands
    // are fresh (no load-use stall).
    assign acc = flush_ctrl & ~stall & (state_q == S_RUN);

    // Next-state, next-PC and squash decision.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redirect_d  = redirect_q;
        if_id_flush = 1'b0;
        case (state_q)
            S_RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (acc) begin
                    if_id_flush = 1'b1;
                    if (imem_ready) begin
                        pc_d = tgt;
                    end else begin
                        redirect_d = tgt;
                        state_d    = S_REDIR;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_next_seq;
                end
            end
            S_REDIR: begin
                // ID only carries bubbles here, so flush_ctrl/stall are ignored.
                if_id_flush = 1'b1;
                if (imem_ready) begin
                    pc_d    = redirect_q;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // PC, pending target and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc            = pc_q;
    assign redirect_pend = (state_q == S_REDIR);

`ifdef BRANCH_PERF_CNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (acc),
        .cnt_o (taken_cnt)
    );
`else
    assign taken_cnt = '0;
`endif

endmodule
